// File: rtl/multiply_if.sv
// Operand/result bundle for the shift-add multiply-accumulate block.
// The requester drives start and the operands; the block returns p, busy, done and error.
interface multiply_if #(
  parameter int SIZE = 5
);
  logic              start;
  logic [SIZE-1:0]   q;
  logic [SIZE-1:0]   y;
  logic [SIZE-1:0]   r;
  logic [2*SIZE-1:0] p;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output start, q, y, r,
    input  p, busy, done, error
  );

  modport slave (
    input  start, q, y, r,
    output p, busy, done, error
  );
endinterface

// File: rtl/multiply.sv
// Sequential shift-add unit computing p = q*y + r in exactly SIZE iterations.
// Define MULTIPLY_CHECK_EN to enable the (r >= y) operand-consistency flag on error.
module multiply #(
  parameter int SIZE = 5
) (
  input  logic     clk,
  input  logic     rst,
  multiply_if.slave bus
);
  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_reg, state_next;
  logic [2*SIZE-1:0] acc_reg, mcand_reg, p_reg;
  logic [2*SIZE-1:0] acc_sum;
  logic [SIZE-1:0]   mplier_reg;
  logic [CW-1:0]     count_reg;
  logic              last_iter;

  // The final iteration's sum goes straight into p so done lands on the SIZE-th edge.
  assign acc_sum   = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
  assign last_iter = (count_reg == CW'(SIZE - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
      p_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            acc_reg    <= {{SIZE{1'b0}}, bus.r};
            mcand_reg  <= {{SIZE{1'b0}}, bus.y};
            mplier_reg <= bus.q;
            count_reg  <= '0;
          end
        end
        RUN: begin
          acc_reg    <= acc_sum;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          count_reg  <= count_reg + 1'b1;
          if (last_iter) begin
            p_reg <= acc_sum;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.p    = p_reg;
  assign bus.busy = (state_reg != IDLE);
  assign bus.done = (state_reg == DONE);

`ifdef MULTIPLY_CHECK_EN
  logic [SIZE-1:0] r_reg, y_reg;
  logic            error_reg;

  // Operands are captured at start so later input changes cannot disturb the flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_reg     <= '0;
      y_reg     <= '0;
      error_reg <= 1'b0;
    end else begin
      if (state_reg == IDLE && bus.start) begin
        r_reg <= bus.r;
        y_reg <= bus.y;
      end
      if (state_reg == RUN && last_iter) begin
        error_reg <= (r_reg >= y_reg);
      end
    end
  end

  assign bus.error = error_reg;
`else
  assign bus.error = 1'b0;
`endif

endmodule

// File: tb/tb_multiply.sv
// Scoreboard bench for multiply: stimulus pushes expected results, a monitor checks each done pulse.
module tb_multiply;
  localparam int SIZE = 5;
`ifdef MULTIPLY_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic [2*SIZE-1:0] p;
    logic              err;
    int                cyc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  multiply_if #(.SIZE(SIZE)) bus ();

  multiply #(.SIZE(SIZE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && bus.done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pulse", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (bus.p !== e.p || bus.error !== e.err || cyc != e.cyc) begin
          errors++;
          $display("FAIL result: got p=%0d error=%0b cycle=%0d, required p=%0d error=%0b cycle=%0d",
                   bus.p, bus.error, cyc, e.p, e.err, e.cyc);
        end else begin
          $display("result p=%0d error=%0b at cycle %0d ok", bus.p, bus.error, cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end else begin
      $display("check %s = %0d ok", name, got);
    end
  endtask

  // Drive one start cycle; optionally record the hand-computed expectation.
  task automatic issue(input logic [SIZE-1:0] q, input logic [SIZE-1:0] y, input logic [SIZE-1:0] r,
                       input logic [2*SIZE-1:0] exp_p, input logic exp_err, input bit push);
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    bus.q     = q;
    bus.y     = y;
    bus.r     = r;
    if (push) begin
      e.p   = exp_p;
      e.err = exp_err & CHK;
      e.cyc = cyc + 1 + SIZE;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    // Scramble operands after sampling; the result in progress must not change.
    bus.q = ~q;
    bus.y = ~y;
    bus.r = ~r;
    check("busy_after_start", {31'd0, bus.busy}, 32'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout: got no done within 20 cycles, required a pulse");
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.q     = '0;
    bus.y     = '0;
    bus.r     = '0;
    repeat (2) @(negedge clk);
    check("reset_p", {22'd0, bus.p}, 32'd0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_done", {31'd0, bus.done}, 32'd0);
    check("reset_error", {31'd0, bus.error}, 32'd0);
    rst = 1'b1;

    // Basic op with a start re-assertion during RUN that must be ignored.
    issue(5'd6, 5'd5, 5'd3, 10'd33, 1'b0, 1'b1);
    bus.start = 1'b1;
    bus.q = 5'd1; bus.y = 5'd1; bus.r = 5'd0;
    @(negedge clk);
    bus.start = 1'b0;
    check("p_held_during_run", {22'd0, bus.p}, 32'd0);
    wait_done();
    repeat (6) @(negedge clk);
    check("p_held_after_done", {22'd0, bus.p}, 32'd33);

    // Max operands, then a back-to-back start one cycle after done.
    issue(5'd31, 5'd31, 5'd30, 10'd991, 1'b0, 1'b1);
    wait_done();
    issue(5'd0, 5'd0, 5'd0, 10'd0, 1'b1, 1'b1);
    wait_done();

    // Consistency-flag vectors and zero-operand boundaries.
    issue(5'd2, 5'd4, 5'd4, 10'd12, 1'b1, 1'b1);
    wait_done();
    issue(5'd3, 5'd0, 5'd0, 10'd0, 1'b1, 1'b1);
    wait_done();
    issue(5'd0, 5'd9, 5'd17, 10'd17, 1'b1, 1'b1);
    wait_done();
    issue(5'd10, 5'd0, 5'd5, 10'd5, 1'b1, 1'b1);
    wait_done();
    issue(5'd13, 5'd11, 5'd1, 10'd144, 1'b0, 1'b1);
    wait_done();

    // Asynchronous reset mid-RUN abandons the operation.
    issue(5'd31, 5'd31, 5'd31, 10'd0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    check("async_rst_p", {22'd0, bus.p}, 32'd0);
    check("async_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("async_rst_done", {31'd0, bus.done}, 32'd0);
    check("async_rst_error", {31'd0, bus.error}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("no_done_after_rst", {31'd0, bus.busy}, 32'd0);

    issue(5'd7, 5'd3, 5'd2, 10'd23, 1'b0, 1'b1);
    wait_done();
    repeat (10) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
